// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants and helpers for the asynchronous FIFO.
//                Provides the default address width, derived depth and
//                pointer-width constants, and a Gray-to-binary converter.
//                The converter is used by the write controller only when
//                ALMOST_FULL_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DEPTH      = 1 << DEF_ADDR_WIDTH;
    localparam int DEF_PTR_W      = DEF_ADDR_WIDTH + 1;

    // Generic 32-bit Gray-to-binary conversion. Callers zero-extend narrower
    // pointers; leading zeros leave the low bits of the result unchanged.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin = '0;
        for (int i = 0; i < 32; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/bin2gray.sv
`default_nettype none
// ============================================================================
//  Module      : bin2gray
//  Description : Combinational binary-to-Gray converter.
//  Ports       : bin  (in,  WIDTH) binary value
//                gray (out, WIDTH) reflected Gray code of bin
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2gray #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule : bin2gray
`default_nettype wire

// File: rtl/fifo_wptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wptr_ctrl
//  Description : Write-side pointer controller of the asynchronous FIFO
//                (write-clock domain). Keeps the binary write pointer,
//                drives the RAM write address/enable, publishes the
//                registered Gray pointer and a registered full flag computed
//                against the read pointer synchronized into this domain.
//  Ports       : wclk          (in)  write clock
//                wrst_n        (in)  asynchronous active-low reset
//                winc          (in)  write request
//                wq2_rptr      (in)  synchronized Gray read pointer
//                wen           (out) RAM write enable (winc & ~wfull)
//                waddr         (out) RAM write address
//                wptr          (out) registered Gray write pointer
//                wfull         (out) registered full flag
//                wovf          (out) one-cycle pulse on a rejected write
//                walmost_full  (out) registered almost-full (macro only)
//  Config      : ALMOST_FULL_EN - adds walmost_full, AFULL_THRESH and the
//                fill-level computation.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
`ifdef ALMOST_FULL_EN
    ,
    parameter int AFULL_THRESH = 2
`endif
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic                  wovf
`ifdef ALMOST_FULL_EN
    ,
    output logic                  walmost_full
`endif
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    // Gray pointers one full lap apart differ exactly in their top two bits.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (ADDR_WIDTH - 1);

    logic [PTR_W-1:0] wbin_q, wbin_d;
    logic [PTR_W-1:0] wptr_q, wgray_d;
    logic             wfull_q, wfull_d;
    logic             wovf_q, wovf_d;

    assign wen    = winc & ~wfull_q;
    assign wbin_d = wbin_q + {{ADDR_WIDTH{1'b0}}, wen};

    bin2gray #(
        .WIDTH (PTR_W)
    ) u_bin2gray (
        .bin  (wbin_d),
        .gray (wgray_d)
    );

    assign wfull_d = (wgray_d == (wq2_rptr ^ FULL_MASK));
    assign wovf_d  = winc & wfull_q;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q  <= '0;
            wptr_q  <= '0;
            wfull_q <= 1'b0;
            wovf_q  <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wptr_q  <= wgray_d;
            wfull_q <= wfull_d;
            wovf_q  <= wovf_d;
        end
    end

    assign waddr = wbin_q[ADDR_WIDTH-1:0];
    assign wptr  = wptr_q;
    assign wfull = wfull_q;
    assign wovf  = wovf_q;

`ifdef ALMOST_FULL_EN
    localparam logic [PTR_W-1:0] AFULL_LEVEL =
        PTR_W'((1 << ADDR_WIDTH) - AFULL_THRESH);

    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] fill;
    logic             walmost_full_q, walmost_full_d;

    // Fill is taken against the post-write pointer so almost-full lines up
    // with wfull in timing.
    assign rbin           = PTR_W'(gray2bin(32'(wq2_rptr)));
    assign fill           = wbin_d - rbin;
    assign walmost_full_d = (fill >= AFULL_LEVEL);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            walmost_full_q <= 1'b0;
        end else begin
            walmost_full_q <= walmost_full_d;
        end
    end

    assign walmost_full = walmost_full_q;
`endif

endmodule : fifo_wptr_ctrl
`default_nettype wire

// File: tb/tb_fifo_wptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wptr_ctrl
//  Description : Self-checking bench for fifo_wptr_ctrl with ADDR_WIDTH=2
//                (depth 4, 3-bit pointers). A reference model pushes the
//                expected post-edge state into a queue as each cycle is
//                driven; it is popped and compared after the edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wptr_ctrl;

    logic       wclk = 1'b0;
    logic       wrst_n = 1'b0;
    logic       winc = 1'b0;
    logic [2:0] wq2_rptr = 3'b000;
    logic       wen;
    logic [1:0] waddr;
    logic [2:0] wptr;
    logic       wfull;
    logic       wovf;
    logic       walmost_full_obs;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0] waddr;
        logic [2:0] wptr;
        logic       wfull;
        logic       wovf;
        logic       afull;
    } exp_t;

    exp_t exp_q[$];

    // Reference state
    logic [2:0] m_bin;
    logic       m_full;
    logic [2:0] prev_wptr;

    // Binary-to-Gray lookup for 3-bit pointers.
    logic [2:0] gtab [8];
    initial begin
        gtab[0] = 3'b000; gtab[1] = 3'b001; gtab[2] = 3'b011; gtab[3] = 3'b010;
        gtab[4] = 3'b110; gtab[5] = 3'b111; gtab[6] = 3'b101; gtab[7] = 3'b100;
    end

`ifdef ALMOST_FULL_EN
    fifo_wptr_ctrl #(
        .ADDR_WIDTH   (2),
        .AFULL_THRESH (1)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .wen          (wen),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .wovf         (wovf),
        .walmost_full (walmost_full_obs)
    );
`else
    fifo_wptr_ctrl #(
        .ADDR_WIDTH (2)
    ) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .winc     (winc),
        .wq2_rptr (wq2_rptr),
        .wen      (wen),
        .waddr    (waddr),
        .wptr     (wptr),
        .wfull    (wfull),
        .wovf     (wovf)
    );
    assign walmost_full_obs = 1'b0;
`endif

    always #5 wclk = ~wclk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [2:0] gray2bin3(input logic [2:0] g);
        logic [2:0] b;
        b = 3'b000;
        for (int i = 0; i < 8; i++) begin
            if (gtab[i] == g) b = 3'(i);
        end
        return b;
    endfunction

    task automatic model_reset();
        m_bin     = 3'b000;
        m_full    = 1'b0;
        prev_wptr = 3'b000;
    endtask

    // Drive one cycle, check wen combinationally, then compare post-edge state.
    task automatic step(input logic inc, input logic [2:0] rq);
        exp_t       e;
        logic       acc;
        logic [2:0] fill;
        winc     = inc;
        wq2_rptr = rq;
        #1;
        acc = inc & ~m_full;
        chk("wen", {7'd0, wen}, {7'd0, acc});
        e.waddr = m_bin[1:0];
        e.wovf  = inc & m_full;
        if (acc) m_bin = m_bin + 3'd1;
        e.waddr = m_bin[1:0];
        e.wptr  = gtab[m_bin];
        m_full  = (gtab[m_bin] == (rq ^ 3'b110));
        e.wfull = m_full;
        fill    = m_bin - gray2bin3(rq);
        e.afull = (fill >= 3'd3);
        exp_q.push_back(e);
        @(posedge wclk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 8'd1, 8'd0);
        end else begin
            e = exp_q.pop_front();
            chk("waddr", {6'd0, waddr}, {6'd0, e.waddr});
            chk("wptr",  {5'd0, wptr},  {5'd0, e.wptr});
            chk("wfull", {7'd0, wfull}, {7'd0, e.wfull});
            chk("wovf",  {7'd0, wovf},  {7'd0, e.wovf});
`ifdef ALMOST_FULL_EN
            chk("walmost_full", {7'd0, walmost_full_obs}, {7'd0, e.afull});
`endif
            chk("wptr_onebit", {7'd0, ($countones(wptr ^ prev_wptr) <= 1)}, 8'd1);
            prev_wptr = wptr;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_waddr"}, {6'd0, waddr}, 8'd0);
        chk({tag, "_wptr"},  {5'd0, wptr},  8'd0);
        chk({tag, "_wfull"}, {7'd0, wfull}, 8'd0);
        chk({tag, "_wovf"},  {7'd0, wovf},  8'd0);
        chk({tag, "_afull"}, {7'd0, walmost_full_obs}, 8'd0);
    endtask

    task automatic do_reset();
        @(posedge wclk);
        #1;
        wrst_n = 1'b0;
        winc   = 1'b0;
        #2;
        wrst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        // Reset held from time zero
        @(posedge wclk);
        #1;
        check_zero("rst");
        wrst_n = 1'b1;

        // Mid-burst reset: two writes, then reset asserted mid-cycle with winc=1
        step(1'b1, 3'b000);
        step(1'b1, 3'b000);
        chk("pre_rst_wptr", {5'd0, wptr}, 8'h03);
        winc = 1'b1;
        #2;
        wrst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(posedge wclk);
        #1;
        check_zero("held_rst");
        wrst_n = 1'b1;
        model_reset();

        // Fill from empty: wptr 001,011,010,110 then full
        step(1'b1, 3'b000);
        step(1'b1, 3'b000);
        step(1'b1, 3'b000);
        step(1'b1, 3'b000);
        chk("fill_wptr", {5'd0, wptr}, 8'h06);
        chk("fill_wfull", {7'd0, wfull}, 8'd1);

        // Overflow: rejected write, one-cycle wovf
        step(1'b1, 3'b000);
        chk("ovf_pulse", {7'd0, wovf}, 8'd1);
        chk("ovf_wptr_hold", {5'd0, wptr}, 8'h06);
        step(1'b0, 3'b000);
        chk("ovf_clear", {7'd0, wovf}, 8'd0);

        // Release by read advance, then refill
        step(1'b0, 3'b001);
        chk("release_wfull", {7'd0, wfull}, 8'd0);
        step(1'b1, 3'b001);
        chk("refill_wptr", {5'd0, wptr}, 8'h07);
        chk("refill_wfull", {7'd0, wfull}, 8'd1);

        // Wrap: eight writes with the read pointer one behind
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, gtab[3'(m_bin - 3'd1)]);
        end
        chk("wrap_wptr", {5'd0, wptr}, 8'h00);
        chk("wrap_waddr", {6'd0, waddr}, 8'h00);

`ifdef ALMOST_FULL_EN
        // Almost-full with threshold 1
        do_reset();
        step(1'b1, 3'b000);
        step(1'b1, 3'b000);
        chk("af_two", {7'd0, walmost_full_obs}, 8'd0);
        step(1'b1, 3'b000);
        chk("af_three", {7'd0, walmost_full_obs}, 8'd1);
        step(1'b1, 3'b000);
        chk("af_full", {7'd0, wfull}, 8'd1);
        step(1'b0, 3'b011);
        chk("af_clear", {7'd0, walmost_full_obs}, 8'd0);
        chk("af_full_clear", {7'd0, wfull}, 8'd0);
`endif

        winc = 1'b0;
        #20;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fifo_wptr_ctrl
`default_nettype wire
